// File: rtl/decoder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_arb_pkg
// Description : Shared sizes, FSM state type and helpers for decoder_rr_arbiter
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2,
        GUARD  = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Rotating-priority search: first eligible index at or after ptr
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import decoder_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               found_o,
    output logic [ID_W-1:0]    id_o
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        found_o = 1'b0;
        id_o    = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr_i + ID_W'(k);
            if (eligible_i[idx]) begin
                found_o = 1'b1;
                id_o    = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : decoder_rr_arbiter
// Description : Round-robin owner of a 74138-style 3-to-8 chip-select decoder
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_rr_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int SETUP_CYCLES = 1,
    parameter int MAX_HOLD     = 16,
    parameter int GUARD_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    output logic               select_a_o,
    output logic               select_b_o,
    output logic               select_c_o,
    output logic               g1_en_o,
    output logic               g2a_en_n_o,
    output logic               g2b_en_n_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               busy_o,
    output logic               timeout_o
);

    localparam int CNT_W = $clog2(max3(SETUP_CYCLES, MAX_HOLD, GUARD_CYCLES)) + 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 en_q, en_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   eligible;
    logic                 pick_found;
    logic [ID_W-1:0]      pick_id;

    assign eligible = req_i & ~mask_i;

    rr_picker u_picker (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .found_o    (pick_found),
        .id_o       (pick_id)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        id_d      = id_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_found) begin
                    id_d    = pick_id;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (!eligible[id_q]) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    ptr_d   = id_q + ID_W'(1);
                end else if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    ptr_d   = id_q + ID_W'(1);
                end
            end
            ACTIVE: begin
                // A dropped request takes precedence over hold expiry: no timeout.
                if (!eligible[id_q]) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    ptr_d   = id_q + ID_W'(1);
                end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    state_d   = GUARD;
                    cnt_d     = '0;
                    ptr_d     = id_q + ID_W'(1);
                    timeout_d = 1'b1;
                end
            end
            GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        en_d   = (state_d == ACTIVE);
        gnt_d  = en_d ? (NUM_REQ'(1) << id_d) : '0;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            en_q      <= 1'b0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            en_q      <= en_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign select_a_o = id_q[0];
    assign select_b_o = id_q[1];
    assign select_c_o = id_q[2];
    assign g1_en_o    = en_q;
    assign g2a_en_n_o = ~en_q;
    assign g2b_en_n_o = ~en_q;
    assign gnt_o      = gnt_q;
    assign gnt_id_o   = id_q;
    assign busy_o     = busy_q;
    assign timeout_o  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_rr_arbiter
// Description : Randomized bench for decoder_rr_arbiter against a cycle model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_rr_arbiter;

    localparam int PH_IDLE = 0, PH_SETUP = 1, PH_ACTIVE = 2, PH_GUARD = 3;

    typedef struct {
        int phase;
        int id;
        int ptr;
        int left;
        bit tmo;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req, mask;

    logic       a_sa, a_sb, a_sc, a_g1, a_g2a, a_g2b, a_busy, a_tmo;
    logic [7:0] a_gnt;
    logic [2:0] a_id;
    logic       b_sa, b_sb, b_sc, b_g1, b_g2a, b_g2b, b_busy, b_tmo;
    logic [7:0] b_gnt;
    logic [2:0] b_id;

    int   n_vec = 0;
    int   n_err = 0;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    decoder_rr_arbiter #(.SETUP_CYCLES(1), .MAX_HOLD(16), .GUARD_CYCLES(1)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .mask_i(mask),
        .select_a_o(a_sa), .select_b_o(a_sb), .select_c_o(a_sc),
        .g1_en_o(a_g1), .g2a_en_n_o(a_g2a), .g2b_en_n_o(a_g2b),
        .gnt_o(a_gnt), .gnt_id_o(a_id), .busy_o(a_busy), .timeout_o(a_tmo)
    );

    decoder_rr_arbiter #(.SETUP_CYCLES(4), .MAX_HOLD(5), .GUARD_CYCLES(2)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .mask_i(mask),
        .select_a_o(b_sa), .select_b_o(b_sb), .select_c_o(b_sc),
        .g1_en_o(b_g1), .g2a_en_n_o(b_g2a), .g2b_en_n_o(b_g2b),
        .gnt_o(b_gnt), .gnt_id_o(b_id), .busy_o(b_busy), .timeout_o(b_tmo)
    );

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = PH_IDLE; m.id = 0; m.ptr = 0; m.left = 0; m.tmo = 1'b0;
        return m;
    endfunction

    // One clock of the arbitration rules, with explicit remaining-cycle budgets.
    function automatic mdl_t mdl_step(mdl_t m, logic [7:0] elig, int s, int h, int g);
        mdl_t n;
        bit   done;
        n     = m;
        n.tmo = 1'b0;
        done  = 1'b0;
        case (m.phase)
            PH_IDLE: begin
                for (int k = 0; k < 8; k++) begin
                    if (!done && elig[(m.ptr + k) % 8]) begin
                        n.id = (m.ptr + k) % 8; n.phase = PH_SETUP; n.left = s; done = 1'b1;
                    end
                end
            end
            PH_SETUP: begin
                if (!elig[m.id]) begin
                    n.phase = PH_GUARD; n.left = g; n.ptr = (m.id + 1) % 8;
                end else begin
                    n.left = m.left - 1;
                    if (n.left == 0) begin
                        n.phase = PH_ACTIVE; n.left = h; n.ptr = (m.id + 1) % 8;
                    end
                end
            end
            PH_ACTIVE: begin
                if (!elig[m.id]) begin
                    n.phase = PH_GUARD; n.left = g; n.ptr = (m.id + 1) % 8;
                end else begin
                    n.left = m.left - 1;
                    if (n.left == 0) begin
                        n.phase = PH_GUARD; n.left = g; n.ptr = (m.id + 1) % 8; n.tmo = 1'b1;
                    end
                end
            end
            default: begin
                n.left = m.left - 1;
                if (n.left == 0) n.phase = PH_IDLE;
            end
        endcase
        return n;
    endfunction

    // {sel[2:0], g1, g2a_n, g2b_n, gnt[7:0], id[2:0], busy, timeout}
    function automatic logic [31:0] mdl_out(mdl_t m);
        logic       en;
        logic [2:0] id3;
        logic [7:0] g;
        en  = (m.phase == PH_ACTIVE);
        id3 = 3'(m.id);
        g   = en ? (8'd1 << id3) : 8'd0;
        return {13'd0, id3, en, !en, !en, g, id3, (m.phase != PH_IDLE), m.tmo};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, "_a"}, {13'd0, a_sc, a_sb, a_sa, a_g1, a_g2a, a_g2b, a_gnt, a_id, a_busy, a_tmo}, mdl_out(ma));
        check_val({tag, "_b"}, {13'd0, b_sc, b_sb, b_sa, b_g1, b_g2a, b_g2b, b_gnt, b_id, b_busy, b_tmo}, mdl_out(mb));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            ma = mdl_reset(); mb = mdl_reset();
        end else begin
            ma = mdl_step(ma, req & ~mask, 1, 16, 1);
            mb = mdl_step(mb, req & ~mask, 4, 5, 2);
        end
        @(negedge clk);
        compare_all("cyc");
    endtask

    // Called at a negedge; reset takes effect without any clock edge.
    task automatic apply_reset(input logic [7:0] req_during);
        req   = req_during;
        rst_n = 1'b0;
        #1;
        ma = mdl_reset(); mb = mdl_reset();
        compare_all("rst_async");
        tick();
        tick();
        req   = 8'h00;
        mask  = 8'h00;
        rst_n = 1'b1;
    endtask

    initial begin : main
        int         exp_id, grants;
        logic [7:0] prev_gnt;
        rst_n = 1'b1; req = 8'h00; mask = 8'h00;
        ma = mdl_reset(); mb = mdl_reset();
        @(negedge clk);
        apply_reset(8'hFF);

        // Single grant to requester 5, released at cycle 6
        req = 8'h20;
        tick();
        check_val("single_sel", {29'd0, a_sc, a_sb, a_sa}, 32'd5);
        check_val("single_en_c1", {31'd0, a_g1}, 32'd0);
        tick();
        check_val("single_gnt", {24'd0, a_gnt}, 32'h20);
        for (int i = 0; i < 4; i++) tick();
        req = 8'h00;
        tick();
        check_val("single_rel", {29'd0, a_g1, a_g2a, a_g2b}, 32'b011);
        tick();
        check_val("single_idle", {31'd0, a_busy}, 32'd0);

        // Round-robin between 0 and 7, each released by timeout
        apply_reset(8'h00);
        req = 8'h81; exp_id = 0; grants = 0; prev_gnt = 8'h00;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (a_gnt != 8'h00 && prev_gnt == 8'h00) begin
                check_val("rr_order", {29'd0, a_id}, 32'(exp_id));
                exp_id = (exp_id == 0) ? 7 : 0;
                grants++;
            end
            prev_gnt = a_gnt;
        end
        check_val("rr_grants", {31'd0, (grants >= 4)}, 32'd1);

        // Masked request is ignored, then a mid-ACTIVE mask release
        apply_reset(8'h00);
        mask = 8'h01; req = 8'h01;
        for (int i = 0; i < 5; i++) tick();
        check_val("mask_busy", {31'd0, a_busy}, 32'd0);
        mask = 8'h00; req = 8'h08;
        tick();
        tick();
        check_val("mask_gnt", {24'd0, a_gnt}, 32'h08);
        mask = 8'h08;
        tick();
        check_val("mask_rel", {30'd0, a_g1, a_tmo}, 32'd0);
        tick();

        // Abort during SETUP on the 4-cycle-setup instance, then pointer is 5
        apply_reset(8'h00);
        req = 8'h10;
        tick();
        tick();
        req = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        check_val("abort_en", {31'd0, b_g1}, 32'd0);
        req = 8'h21;
        tick();
        check_val("abort_ptr", {29'd0, b_id}, 32'd5);
        for (int i = 0; i < 6; i++) tick();

        // Asynchronous reset in the middle of an ACTIVE grant
        apply_reset(8'h00);
        req = 8'h08;
        tick();
        tick();
        check_val("mid_active", {31'd0, a_g1}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_en", {26'd0, a_g1, a_g2a, a_g2b, b_g1, b_g2a, b_g2b}, 32'b011011);
        ma = mdl_reset(); mb = mdl_reset();
        compare_all("async_all");
        @(negedge clk);
        apply_reset(8'h08);

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) req = req ^ (8'd1 << $urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 299) == 0) apply_reset(8'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
